serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 16 +
 rtl/serial_adder_full_adder.sv | 20 ++
 rtl/serial_adder.sv | 151 +++++++++++++++
 tb/tb_serial_adder.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package serial_adder_pkg;

    // Default operand/result width.
    localparam int DEFAULT_WIDTH = 8;

    // Control states: wait for start, shift one bit per cycle, present result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder, the only arithmetic cell of the serial adder.
// Latency: purely combinational.
// Backpressure: none (no handshake).
module full_adder
    import serial_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // Sum and majority carry of the three input bits.
    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule : full_adder

// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first through one full adder; optional signed overflow via SERIAL_ADDER_OVF_EN.
// Latency: WIDTH+1 cycles from accepted start to the one-cycle done pulse.
// Backpressure: start is honoured only in IDLE (busy low); requests while busy are dropped.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             cout,
    output logic             ovf
`else
    output logic             cout
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic             fa_s;
    logic             fa_c;
    logic             accept;
    logic             last_step;

    // The one and only arithmetic cell, fed by the shift-register LSBs.
    full_adder u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_c)
    );

    assign accept    = (state_q == IDLE) && start;
    assign last_step = (state_q == RUN) && (cnt_q == CNT_W'(WIDTH - 1));

    // State register; reset aborts any addition in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: RUN lasts exactly WIDTH cycles, DONE exactly one.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_step) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded straight from the state.
    always_comb begin
        busy = (state_q == RUN) || (state_q == DONE);
        done = (state_q == DONE);
    end

    // Datapath next-state: load on accept, one bit per RUN cycle, publish on the last bit.
    always_comb begin
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        cnt_d    = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d    = ovf_q;
`endif
        if (accept) begin
            a_sh_d  = a;
            b_sh_d  = b;
            carry_d = cin;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            carry_d  = fa_c;
            cnt_d    = cnt_q + CNT_W'(1);
            if (last_step) begin
                sum_d  = {fa_s, sum_sh_q[WIDTH-1:1]};
                cout_d = fa_c;
`ifdef SERIAL_ADDER_OVF_EN
                // carry_q here is the carry into the MSB position.
                ovf_d  = carry_q ^ fa_c;
`endif
            end
        end
    end

    // Datapath registers; the published result only moves on the last RUN step.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            cnt_q    <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            cnt_q    <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8): directed vectors, ignored starts, reset abort.
// Latency: checks done arrives WIDTH+1 cycles after the start edge.
// Backpressure: checks busy over RUN/DONE and that starts while busy are dropped.
module tb_serial_adder;

    localparam int W      = 8;
    localparam int PERIOD = 10;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        longint       t0;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   total    = 0;
    int   bad      = 0;
    int   done_cnt = 0;
    int   n_push   = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
`ifdef SERIAL_ADDER_OVF_EN
        .cout  (cout),
        .ovf   (ovf)
`else
        .cout  (cout)
`endif
    );

`ifndef SERIAL_ADDER_OVF_EN
    assign ovf = 1'b0;
`endif

    initial clk = 1'b0;
    always #(PERIOD / 2) clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse pops one expected result and checks it.
    always @(negedge clk) begin
        exp_t e;
        longint lat;
        if (done === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e   = sb.pop_front();
                lat = ($time - e.t0) / PERIOD;
                chk({e.name, "_sum"}, 32'(sum), 32'(e.sum));
                chk({e.name, "_cout"}, 32'(cout), 32'(e.cout));
                chk({e.name, "_latency"}, 32'(lat), 32'(W + 1));
`ifdef SERIAL_ADDER_OVF_EN
                chk({e.name, "_ovf"}, 32'(ovf), 32'(e.ovf));
`endif
            end
        end
    end

    // Issue one add; optionally hammer start with junk operands during RUN and DONE.
    task automatic run_add(input string nm, input logic [W-1:0] va, input logic [W-1:0] vb,
                           input logic vc, input logic [W-1:0] es, input logic ec,
                           input logic eo, input bit inject);
        exp_t e;
        @(negedge clk);
        a     = va;
        b     = vb;
        cin   = vc;
        start = 1'b1;
        e.sum = es; e.cout = ec; e.ovf = eo; e.t0 = $time; e.name = nm;
        sb.push_back(e);
        n_push++;
        for (int i = 1; i <= W + 1; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (inject && (i == 3 || i == W + 1)) begin
                start = 1'b1;
                a     = 8'hFF;
                b     = 8'hFF;
                cin   = 1'b1;
            end
            chk({nm, "_busy"}, 32'(busy), 32'd1);
        end
        @(negedge clk);
        start = 1'b0;
        chk({nm, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        rst = 1'b0;

        run_add("v5a3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 1'b0);
        run_add("vff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        run_add("v7f01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        run_add("v0000c", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        run_add("vaa55c", 8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        run_add("vinject", 8'h21, 8'h43, 1'b0, 8'h64, 1'b0, 1'b0, 1'b1);

        // Reset four cycles into RUN: operation aborts with no done.
        @(negedge clk);
        a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        repeat (12) @(negedge clk);

        // Reset and start together: reset wins, nothing starts.
        rst = 1'b1; start = 1'b1; a = 8'h01; b = 8'h01;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_start_busy", 32'(busy), 32'd0);
        repeat (12) @(negedge clk);

        run_add("v1020", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("done_count", 32'(done_cnt), 32'(n_push));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_serial_adder
